// File: rtl/div_long_small_pkg.sv
// Shared types and default sizing for the limb-wise long divider.
package div_long_small_pkg;

   localparam int DEF_WIDTH      = 16;
   localparam int DEF_L          = 4;
   localparam int DEF_INT_DIGITS = 2;
   localparam int DEF_MAX        = 10000;
   localparam int DEF_DW         = 16;

   typedef logic [DEF_WIDTH-1:0] limb_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      ITER = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/div_long_small_if.sv
// Request/result bundle between the series accumulator and the long divider.
interface div_long_small_if
   import div_long_small_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int L     = DEF_L,
   parameter int DW    = DEF_DW
);
   logic               start;
   logic [L*WIDTH-1:0] a;
   logic [DW-1:0]      d;
   logic               busy;
   logic               finish;
   logic [L*WIDTH-1:0] c;
   logic [DW-1:0]      rem;
   logic               q_zero;
   logic               div_zero;

   modport master (output start, a, d,
                   input  busy, finish, c, rem, q_zero, div_zero);

   modport slave  (input  start, a, d,
                   output busy, finish, c, rem, q_zero, div_zero);
endinterface

// File: rtl/div_long_small_step.sv
// One restoring shift/subtract step: shift a numerator bit into the partial
// remainder and subtract the divisor when it fits.
module div_long_small_step #(
   parameter int DW = 16
) (
   input  logic [DW-1:0] i_prem,
   input  logic          i_nbit,
   input  logic [DW-1:0] i_d,
   output logic [DW-1:0] o_prem,
   output logic          o_qbit
);
   logic [DW:0]   w_trial;
   logic [DW-1:0] w_diff;

   // Incoming partial remainder is < d, so trial < 2*d and trial-d fits DW bits.
   always_comb begin
      w_trial = {i_prem, i_nbit};
      w_diff  = w_trial[DW-1:0] - i_d;
      o_qbit  = (w_trial >= {1'b0, i_d});
      o_prem  = o_qbit ? w_diff : w_trial[DW-1:0];
   end
endmodule

// File: rtl/div_long_small.sv
// Sequential long division of an L-limb base-MAX number by a small integer d.
// Walks limbs MSB to LSB; each limb takes one LOAD cycle plus WIDTH restoring
// steps, so a full division takes L*(WIDTH+1) cycles.
module div_long_small
   import div_long_small_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int L     = DEF_L,
   parameter int MAX   = DEF_MAX,
   parameter int DW    = DEF_DW
) (
   input  logic             i_clk,
   input  logic             i_rst,
   div_long_small_if.slave  bus
);
   localparam int IW = (L > 1) ? $clog2(L) : 1;
   localparam int CW = $clog2(WIDTH + 1);
   localparam int NW = DW + WIDTH;

   state_t             r_state, w_nstate;
   logic               w_accept;
   logic [L*WIDTH-1:0] r_a;
   logic [DW-1:0]      r_d;
   logic [IW-1:0]      r_idx;
   logic [CW-1:0]      r_cnt;
   logic [DW-1:0]      r_prem;
   logic [WIDTH-1:0]   r_num;
   logic [WIDTH-1:0]   r_c [L];
   logic [DW-1:0]      r_rem;
   logic               r_div_zero;
   logic [WIDTH-1:0]   w_limb;
   logic [NW-1:0]      w_cur;
   logic [DW-1:0]      w_step_prem;
   logic               w_qbit;
   logic [WIDTH-1:0]   w_qlimb;
   logic [L*WIDTH-1:0] w_c;

   // Running remainder (< d) times the radix plus the next limb; the upper DW
   // bits of this are already < d, so only WIDTH quotient bits remain.
   assign w_limb  = r_a[r_idx*WIDTH +: WIDTH];
   assign w_cur   = NW'(r_prem) * NW'(MAX) + NW'(w_limb);
   assign w_qlimb = {r_num[WIDTH-2:0], w_qbit};

   div_long_small_step #(.DW(DW)) u_step (
      .i_prem (r_prem),
      .i_nbit (r_num[WIDTH-1]),
      .i_d    (r_d),
      .o_prem (w_step_prem),
      .o_qbit (w_qbit)
   );

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_nstate;
   end

   // Next-state decode; start is only honoured when idle or finished.
   always_comb begin
      w_nstate = r_state;
      w_accept = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            if (bus.start) begin
               w_accept = 1'b1;
               w_nstate = LOAD;
            end
         end
         LOAD: w_nstate = (r_d == '0) ? DONE : ITER;
         ITER: begin
            if (r_cnt == CW'(1)) w_nstate = (r_idx == '0) ? DONE : LOAD;
         end
         default: w_nstate = IDLE;
      endcase
   end

   // Operand capture, limb iteration and quotient/remainder registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_idx      <= '0;
         r_cnt      <= '0;
         r_rem      <= '0;
         r_div_zero <= 1'b0;
         for (int i = 0; i < L; i++) r_c[i] <= '0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (w_accept) begin
                  r_a        <= bus.a;
                  r_d        <= bus.d;
                  r_idx      <= IW'(L - 1);
                  r_prem     <= '0;
                  r_rem      <= '0;
                  r_div_zero <= 1'b0;
                  for (int i = 0; i < L; i++) r_c[i] <= '0;
               end
            end
            LOAD: begin
               if (r_d == '0) begin
                  r_div_zero <= 1'b1;
                  r_rem      <= '0;
               end else begin
                  r_prem <= w_cur[NW-1:WIDTH];
                  r_num  <= w_cur[WIDTH-1:0];
                  r_cnt  <= CW'(WIDTH);
               end
            end
            ITER: begin
               r_prem <= w_step_prem;
               r_num  <= w_qlimb;
               r_cnt  <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) begin
                  r_c[r_idx] <= w_qlimb;
                  if (r_idx == '0) r_rem <= w_step_prem;
                  else             r_idx <= r_idx - IW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   for (genvar gi = 0; gi < L; gi++) begin : g_c
      assign w_c[gi*WIDTH +: WIDTH] = r_c[gi];
   end

   assign bus.c        = w_c;
   assign bus.rem      = r_rem;
   assign bus.busy     = (r_state == LOAD) || (r_state == ITER);
   assign bus.finish   = (r_state == DONE);
   assign bus.q_zero   = (r_state == DONE) && (w_c == '0);
   assign bus.div_zero = r_div_zero;
endmodule

// File: tb/tb_div_long_small.sv
// Directed bench for the limb-wise long divider.
module tb_div_long_small;
   import div_long_small_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_total = 0;
   int   n_bad   = 0;

   div_long_small_if #(.WIDTH(16), .L(4), .DW(16)) bus ();

   div_long_small #(.WIDTH(16), .L(4), .MAX(10000), .DW(16)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   function automatic logic [63:0] limbs(input int l3, input int l2, input int l1, input int l0);
      return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launch one division, optionally poke a stray start mid-run, wait for finish.
   task automatic run_div(input string tag, input logic [63:0] a, input logic [15:0] d,
                          input logic [63:0] exp_c, input logic [15:0] exp_rem,
                          input logic exp_qz, input logic exp_dz, input int exp_lat,
                          input bit poke);
      int lat;
      bus.start = 1'b1;
      bus.a     = a;
      bus.d     = d;
      tick();
      bus.start = 1'b0;
      bus.a     = ~a;
      bus.d     = d + 16'd7;
      check_eq({tag, ".busy_acc"}, 64'(bus.busy), 64'd1);
      check_eq({tag, ".fin_acc"}, 64'(bus.finish), 64'd0);
      lat = 0;
      while (!bus.finish && lat < 200) begin
         if (poke && lat == 30) bus.start = 1'b1;
         tick();
         bus.start = 1'b0;
         lat++;
      end
      check_eq({tag, ".lat"}, 64'(lat), 64'(exp_lat));
      check_eq({tag, ".c"}, bus.c, exp_c);
      check_eq({tag, ".rem"}, 64'(bus.rem), 64'(exp_rem));
      check_eq({tag, ".qz"}, 64'(bus.q_zero), 64'(exp_qz));
      check_eq({tag, ".dz"}, 64'(bus.div_zero), 64'(exp_dz));
      check_eq({tag, ".busy_done"}, 64'(bus.busy), 64'd0);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.a     = '0;
      bus.d     = '0;
      rst       = 1'b1;
      tick();
      tick();
      check_eq("rst.busy", 64'(bus.busy), 64'd0);
      check_eq("rst.fin", 64'(bus.finish), 64'd0);
      check_eq("rst.c", bus.c, 64'd0);
      check_eq("rst.rem", 64'(bus.rem), 64'd0);
      check_eq("rst.qz", 64'(bus.q_zero), 64'd0);
      check_eq("rst.dz", 64'(bus.div_zero), 64'd0);
      rst = 1'b0;
      tick();

      run_div("t1", limbs(1, 0, 0, 0), 16'd3, limbs(0, 3333, 3333, 3333), 16'd1, 1'b0, 1'b0, 68, 1'b0);
      // Result must hold while idle in DONE.
      repeat (5) tick();
      check_eq("t1.hold_fin", 64'(bus.finish), 64'd1);
      check_eq("t1.hold_c", bus.c, limbs(0, 3333, 3333, 3333));

      run_div("t2", limbs(12, 3456, 7890, 1234), 16'd1, limbs(12, 3456, 7890, 1234), 16'd0, 1'b0, 1'b0, 68, 1'b0);
      run_div("t3", limbs(9999, 9999, 9999, 9999), 16'd9999, limbs(1, 1, 1, 1), 16'd0, 1'b0, 1'b0, 68, 1'b0);
      run_div("t4", limbs(0, 0, 0, 5), 16'd65535, limbs(0, 0, 0, 0), 16'd5, 1'b1, 1'b0, 68, 1'b0);
      run_div("t5", limbs(1, 2, 3, 4), 16'd0, limbs(0, 0, 0, 0), 16'd0, 1'b1, 1'b1, 1, 1'b0);
      // Stray start while busy must not disturb the running division.
      run_div("t6", limbs(1, 0, 0, 0), 16'd3, limbs(0, 3333, 3333, 3333), 16'd1, 1'b0, 1'b0, 68, 1'b1);

      // Reset mid-run: limb 3 of 9999.../9999 is already written by cycle 20.
      bus.start = 1'b1;
      bus.a     = limbs(9999, 9999, 9999, 9999);
      bus.d     = 16'd9999;
      tick();
      bus.start = 1'b0;
      repeat (20) tick();
      check_eq("t7.partial_c", bus.c, limbs(1, 0, 0, 0));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("t7.busy", 64'(bus.busy), 64'd0);
      check_eq("t7.fin", 64'(bus.finish), 64'd0);
      check_eq("t7.c", bus.c, 64'd0);
      run_div("t7b", limbs(1, 0, 0, 0), 16'd3, limbs(0, 3333, 3333, 3333), 16'd1, 1'b0, 1'b0, 68, 1'b0);

      // start together with rst: reset wins.
      bus.start = 1'b1;
      bus.a     = limbs(0, 0, 0, 9);
      bus.d     = 16'd2;
      rst       = 1'b1;
      tick();
      rst       = 1'b0;
      bus.start = 1'b0;
      check_eq("t8.busy", 64'(bus.busy), 64'd0);
      check_eq("t8.fin", 64'(bus.finish), 64'd0);
      tick();
      check_eq("t8.busy2", 64'(bus.busy), 64'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
